write_arbiter_ctrl: RTL and testbench

Sequencing arbiter for the shared SRAM write path. It takes the per-port 3-bit priorities produced by priority_decoder, together with per-port ready and eop. It grants exactly one port at a time, choosing strict priority first and round-robin among equal priorities. The grant is held for the whole packet until that port's eop, and the block drives the 4-bit select consumed by priority_decoder and the write datapath mux.

---
 rtl/write_arbiter_ctrl.sv | 86 ++++++++
 tb/tb_write_arbiter_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/write_arbiter_ctrl.sv
// write_arbiter_ctrl: strict-priority / round-robin packet arbiter for the shared SRAM write path.
module write_arbiter_ctrl #(
  parameter int num_of_ports   = 16,
  parameter int priority_width = 3,
  parameter int timeout_cycles = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [num_of_ports*priority_width-1:0] priority_in,
  input  logic [num_of_ports-1:0]                ready,
  input  logic [num_of_ports-1:0]                eop,
  output logic [3:0]                             select,
  output logic [num_of_ports-1:0]                grant,
  output logic                                   grant_valid,
  output logic                                   sop,
  output logic                                   timeout
);
  localparam int cw = timeout_cycles > 1 ? $clog2(timeout_cycles) : 1;
  localparam logic [cw-1:0] cnt_max = cw'(timeout_cycles - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t                    state_q;
  logic [3:0]                rr_ptr_q, win, nxt_ptr;
  logic [cw-1:0]             cnt_q;
  logic [priority_width-1:0] pri [num_of_ports];
  logic [priority_width-1:0] max_pri;
  logic                      found;
  logic [4:0]                idx;
  logic                      done;
  always_comb begin
    max_pri = '0;
    for (int j = 0; j < num_of_ports; j++) begin
      pri[j] = priority_in[j*priority_width +: priority_width];
      if (ready[j] && pri[j] > max_pri) max_pri = pri[j];
    end
    win   = '0;
    found = 1'b0;
    idx   = '0;
    // first top-priority requester at or after rr_ptr, wrapping
    for (int k = 0; k < num_of_ports; k++) begin
      idx = 5'(rr_ptr_q) + 5'(k);
      if (idx >= 5'(num_of_ports)) idx = idx - 5'(num_of_ports);
      if (!found && ready[idx[3:0]] && pri[idx[3:0]] == max_pri) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
  end
  assign nxt_ptr = select == 4'(num_of_ports - 1) ? 4'd0 : select + 4'd1;
  assign done    = eop[select] || cnt_q == cnt_max;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      select      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      sop         <= 1'b0;
      timeout     <= 1'b0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      sop     <= 1'b0;
      timeout <= 1'b0;
      case (state_q)
        IDLE: if (|ready) begin
          state_q     <= BUSY;
          select      <= win;
          grant       <= num_of_ports'(1) << win;
          grant_valid <= 1'b1;
          sop         <= 1'b1;
          cnt_q       <= '0;
        end
        BUSY: if (done) begin
          state_q     <= RELEASE;
          select      <= '0;
          grant       <= '0;
          grant_valid <= 1'b0;
          rr_ptr_q    <= nxt_ptr;
          timeout     <= !eop[select];
        end else begin
          cnt_q <= cnt_q + cw'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_arbiter_ctrl.sv
// tb_write_arbiter_ctrl: directed stimulus with a scoreboard of expected grants checked by a monitor.
module tb_write_arbiter_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] priority_in;
  logic [15:0] ready, eop;
  logic [3:0]  select;
  logic [15:0] grant;
  logic        grant_valid, sop, timeout;
  int          checks = 0, errors = 0;
  int          exp_q[$];
  int          to_exp = 0;
  int          mon_e;
  logic        inv_ok;
  write_arbiter_ctrl #(.num_of_ports(16), .priority_width(3), .timeout_cycles(8)) dut (
    .clk(clk), .rst(rst), .priority_in(priority_in), .ready(ready), .eop(eop),
    .select(select), .grant(grant), .grant_valid(grant_valid), .sop(sop), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_pri(input logic [2:0] p);
    for (int j = 0; j < 16; j++) priority_in[j*3 +: 3] = p;
  endtask
  task automatic wait_sop(input int n);
    int seen = 0;
    for (int c = 0; c < n*6 + 10 && seen < n; c++) begin
      @(negedge clk);
      if (sop) seen++;
    end
    chk("wait_sop", seen, n);
  endtask
  // monitor: every sop must match the next queued winner
  always @(negedge clk) begin
    if (rst) begin
      if (sop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=sel %0d expected=no grant at %0t", select, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_select", 32'(select), 32'(mon_e));
          chk("sb_grant", 32'(grant), 32'(16'(1) << mon_e));
        end
      end
      if (timeout) begin
        checks++;
        if (to_exp == 0) begin
          errors++;
          $display("FAIL sb_timeout actual=1 expected=0 at %0t", $time);
        end else to_exp--;
      end
      inv_ok = grant_valid ? grant == (16'(1) << select) : grant == 16'h0 && select == 4'd0;
      chk("invariant", 32'(inv_ok), 32'd1);
    end
  end
  initial begin
    rst = 1'b0; ready = '0; eop = '0; priority_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_select", 32'(select), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_sop", 32'(sop), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_gv", 32'(grant_valid), 0);
    end
    // strict priority: port 7 alone at priority 6
    set_pri(3'd5);
    priority_in[21 +: 3] = 3'd6;
    ready = 16'hFFFF;
    exp_q.push_back(7);
    wait_sop(1);
    chk("sp_grant", 32'(grant), 32'h0080);
    priority_in[9 +: 3] = 3'd7;
    eop = 16'h0004;
    @(negedge clk);
    chk("sp_sop_pulse", 32'(sop), 0);
    chk("sp_hold_sel", 32'(select), 7);
    chk("sp_eop_other", 32'(grant_valid), 1);
    eop = 16'h0080;
    @(negedge clk);
    chk("rel_gv", 32'(grant_valid), 0);
    chk("rel_grant", 32'(grant), 0);
    eop = '0;
    exp_q.push_back(3);
    @(negedge clk);
    chk("bubble_gv", 32'(grant_valid), 0);
    wait_sop(1);
    eop = 16'h0008;
    ready = '0;
    @(negedge clk);
    eop = '0;
    // round robin among equal priorities, 1-beat packets
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_pri(3'd4);
    ready = 16'hFFFF;
    eop = 16'hFFFF;
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    foreach (exp_q[i]) ;
    exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(7);
    wait_sop(17);
    ready = 16'hFFDF;
    wait_sop(6);
    ready = '0;
    @(negedge clk);
    eop = '0;
    // forced release after 8 busy cycles
    ready = 16'h0008;
    exp_q.push_back(3);
    to_exp++;
    wait_sop(1);
    ready = '0;
    repeat (7) begin
      @(negedge clk);
      chk("to_hold", 32'(grant_valid), 1);
    end
    @(negedge clk);
    chk("to_release", 32'(grant_valid), 0);
    chk("to_pulse", 32'(timeout), 1);
    ready = 16'hFFFF;
    exp_q.push_back(4);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout), 0);
    wait_sop(1);
    eop = 16'h0010;
    ready = '0;
    @(negedge clk);
    eop = '0;
    // eop on the last allowed cycle beats the timeout
    ready = 16'h0008;
    exp_q.push_back(3);
    wait_sop(1);
    ready = '0;
    repeat (7) @(negedge clk);
    chk("eop8_hold", 32'(grant_valid), 1);
    eop = 16'h0008;
    @(negedge clk);
    chk("eop8_release", 32'(grant_valid), 0);
    chk("eop8_no_to", 32'(timeout), 0);
    eop = '0;
    // asynchronous reset mid-packet
    ready = 16'h0200;
    exp_q.push_back(9);
    wait_sop(1);
    ready = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_gv", 32'(grant_valid), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_select", 32'(select), 0);
    @(negedge clk);
    rst = 1'b1;
    ready = 16'hFFFF;
    eop = 16'hFFFF;
    exp_q.push_back(0);
    wait_sop(1);
    ready = '0;
    @(negedge clk);
    eop = '0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("to_drained", 32'(to_exp), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
